// File: rtl/puf_ctrl_pkg.sv
// Shared types and helpers for the PUF challenge/response controller.
package puf_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_FIRE    = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_SAMPLE  = 3'd4,
        ST_WAIT_LO = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } state_e;

    localparam logic [15:0] LFSR_TAPS_DEFAULT = 16'hB400;

    // One Galois LFSR step on a right-aligned register of up to 64 bits;
    // callers zero-extend their register and taps and truncate the result.
    function automatic logic [63:0] lfsr_step(input logic [63:0] cur, input logic [63:0] taps);
        logic [63:0] shifted;
        shifted = {1'b0, cur[63:1]};
        if (cur[0]) begin
            return shifted ^ taps;
        end else begin
            return shifted;
        end
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;

    // Capture the asynchronous input and let the first stage resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/puf_crp_controller.sv
// Drives LFSR challenges into the PUF, handshakes on its ready line and
// packs the sampled response bits (first bit in the MSB) into one word.
module puf_crp_controller
    import puf_ctrl_pkg::*;
#(
    parameter int             N         = 16,
    parameter int             M         = 32,
    parameter int             SETTLE    = 4,
    parameter int             TIMEOUT   = 255,
    parameter logic [N-1:0]   LFSR_TAPS = N'(LFSR_TAPS_DEFAULT)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] seed,
    output logic [N-1:0] challenge,
    output logic         tig_signal,
    input  logic         puf_resp_ready,
    input  logic         puf_resp_bit,
    output logic         busy,
    output logic         resp_valid,
    output logic [M-1:0] resp_word,
    output logic         timeout_err
);

    localparam int IW      = $clog2(M + 1);
    localparam int CNT_MAX = (TIMEOUT > SETTLE) ? TIMEOUT : SETTLE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [N-1:0]  ONE_N  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  ZERO_N = {N{1'b0}};
    localparam logic [M-1:0]  ZERO_M = {M{1'b0}};
    localparam logic [IW-1:0] ZERO_I = {IW{1'b0}};
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};

    state_e        state_q, state_d;
    logic [N-1:0]  lfsr_q, lfsr_d;
    logic [N-1:0]  challenge_q, challenge_d;
    logic          tig_q, tig_d;
    logic          busy_q, busy_d;
    logic          valid_q, valid_d;
    logic [M-1:0]  word_q, word_d;
    logic [M-1:0]  shreg_q, shreg_d;
    logic          terr_q, terr_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  seed_eff;
    logic [N-1:0]  lfsr_next;
    logic          rdy_s;
    logic          bit_s;

    sync2 u_sync_rdy (.clk(clk), .rst_n(rst_n), .d(puf_resp_ready), .q(rdy_s));
    sync2 u_sync_bit (.clk(clk), .rst_n(rst_n), .d(puf_resp_bit),   .q(bit_s));

    // Next-state and datapath decisions; all PUF-side inputs are synchronized.
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        challenge_d = challenge_q;
        tig_d       = tig_q;
        valid_d     = 1'b0;
        word_d      = word_q;
        shreg_d     = shreg_q;
        terr_d      = terr_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        seed_eff    = (seed == ZERO_N) ? ONE_N : seed;
        lfsr_next   = N'(lfsr_step(64'(lfsr_q), 64'(LFSR_TAPS)));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    lfsr_d      = seed_eff;
                    challenge_d = seed_eff;
                    idx_d       = ZERO_I;
                    terr_d      = 1'b0;
                    shreg_d     = ZERO_M;
                    cnt_d       = ZERO_C;
                    state_d     = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    state_d = ST_FIRE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_FIRE: begin
                tig_d   = 1'b1;
                cnt_d   = ZERO_C;
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (rdy_s) begin
                    state_d = ST_SAMPLE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SAMPLE: begin
                shreg_d = {shreg_q[M-2:0], bit_s};
                idx_d   = idx_q + IW'(1);
                lfsr_d  = lfsr_next;
                tig_d   = 1'b0;
                cnt_d   = ZERO_C;
                state_d = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                if (!rdy_s) begin
                    if (idx_q == IW'(M)) begin
                        state_d = ST_DONE;
                    end else begin
                        // Challenge only moves here, while the trigger is low.
                        challenge_d = lfsr_q;
                        cnt_d       = ZERO_C;
                        state_d     = ST_LOAD;
                    end
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                word_d  = shreg_q;
                valid_d = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                terr_d  = 1'b1;
                tig_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                tig_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset aborts any batch immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            lfsr_q      <= ZERO_N;
            challenge_q <= ZERO_N;
            tig_q       <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            word_q      <= ZERO_M;
            shreg_q     <= ZERO_M;
            terr_q      <= 1'b0;
            idx_q       <= ZERO_I;
            cnt_q       <= ZERO_C;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            challenge_q <= challenge_d;
            tig_q       <= tig_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            word_q      <= word_d;
            shreg_q     <= shreg_d;
            terr_q      <= terr_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
        end
    end

    assign challenge   = challenge_q;
    assign tig_signal  = tig_q;
    assign busy        = busy_q;
    assign resp_valid  = valid_q;
    assign resp_word   = word_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_puf_crp_controller.sv
// Self-checking bench for puf_crp_controller with a behavioural PUF model.
`timescale 1ns/1ps
module tb_puf_crp_controller;

    localparam int N       = 16;
    localparam int M       = 32;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 255;
    localparam logic [15:0] TAPS = 16'hB400;

    localparam int MODE_NORMAL   = 0;
    localparam int MODE_LOW      = 1;
    localparam int MODE_STUCK_HI = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] seed = 16'h0000;
    logic [N-1:0] challenge;
    logic         tig_signal;
    logic         puf_resp_ready = 1'b0;
    logic         puf_resp_bit = 1'b0;
    logic         busy;
    logic         resp_valid;
    logic [M-1:0] resp_word;
    logic         timeout_err;

    int checks = 0;
    int failures = 0;

    int           puf_mode = MODE_NORMAL;
    int           rise_dly = 5;
    int           fall_dly = 2;
    logic [N-1:0] bit_key = 16'h0001;
    int           hi_cnt = 0;
    int           lo_cnt = 0;

    int           valid_cnt = 0;
    int           chal_glitch = 0;
    logic         tig_prev = 1'b0;
    logic [N-1:0] chal_prev = 16'h0000;
    logic [N-1:0] trig_q[$];
    logic [M-1:0] last_word = 32'h0;

    puf_crp_controller #(
        .N(N), .M(M), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .LFSR_TAPS(TAPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
        .challenge(challenge), .tig_signal(tig_signal),
        .puf_resp_ready(puf_resp_ready), .puf_resp_bit(puf_resp_bit),
        .busy(busy), .resp_valid(resp_valid), .resp_word(resp_word),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // PUF model: ready rises rise_dly cycles after the trigger, falls fall_dly after it drops.
    always @(posedge clk) begin
        #1;
        if (puf_mode == MODE_LOW) begin
            puf_resp_ready = 1'b0;
            hi_cnt = 0;
        end else if (tig_signal) begin
            lo_cnt = 0;
            if (!puf_resp_ready) begin
                hi_cnt++;
                if (hi_cnt >= rise_dly) begin
                    puf_resp_bit   = ^(challenge & bit_key);
                    puf_resp_ready = 1'b1;
                    hi_cnt = 0;
                end
            end
        end else begin
            hi_cnt = 0;
            if (puf_resp_ready && puf_mode != MODE_STUCK_HI) begin
                lo_cnt++;
                if (lo_cnt >= fall_dly) begin
                    puf_resp_ready = 1'b0;
                    lo_cnt = 0;
                end
            end
        end
    end

    // Observe trigger rises, challenge stability under trigger and valid pulses.
    always @(negedge clk) begin
        if (tig_signal && !tig_prev) trig_q.push_back(challenge);
        if (tig_signal && tig_prev && challenge != chal_prev) chal_glitch++;
        if (resp_valid) valid_cnt++;
        tig_prev  = tig_signal;
        chal_prev = challenge;
    end

    function automatic logic [N-1:0] first_chal(input logic [N-1:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic logic [N-1:0] next_chal(input logic [N-1:0] x);
        logic [N-1:0] h;
        h = x / 16'd2;
        if (x % 16'd2 == 16'd1) h = h ^ TAPS;
        return h;
    endfunction

    function automatic logic [M-1:0] expected_word(input logic [N-1:0] s, input logic [N-1:0] key);
        logic [N-1:0] c;
        logic [M-1:0] w;
        c = first_chal(s);
        w = 32'h0;
        for (int i = 0; i < M; i++) begin
            w[M-1-i] = ^(c & key);
            c = next_chal(c);
        end
        return w;
    endfunction

    function automatic int seq_errors(input logic [N-1:0] s);
        logic [N-1:0] c;
        int errs;
        c = first_chal(s);
        errs = 0;
        if (trig_q.size() != M) errs++;
        for (int i = 0; i < M && i < trig_q.size(); i++) begin
            if (trig_q[i] !== c) errs++;
            c = next_chal(c);
        end
        return errs;
    endfunction

    task automatic do_start(input logic [N-1:0] s);
        @(negedge clk);
        start = 1'b1;
        seed  = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (challenge !== 16'h0 || tig_signal !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0 ||
            resp_word !== 32'h0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_values: chal=%h tig=%b busy=%b valid=%b word=%h terr=%b, required all 0",
                     challenge, tig_signal, busy, resp_valid, resp_word, timeout_err);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || tig_signal !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: busy=%b tig=%b, required 0 0", busy, tig_signal);
        end
    endtask

    task automatic test_seed1();
        int cyc; bit ok; int v0; int errs; logic [M-1:0] exp_w;
        puf_mode = MODE_NORMAL; rise_dly = 5; fall_dly = 2; bit_key = 16'h0001;
        trig_q.delete(); v0 = valid_cnt; chal_glitch = 0;
        exp_w = expected_word(16'h0001, bit_key);
        do_start(16'h0001);
        checks++;
        if (busy !== 1'b1 || challenge !== 16'h0001) begin
            failures++;
            $display("FAIL start_latency: busy=%b chal=%h, required 1 0001", busy, challenge);
        end
        repeat (SETTLE) @(negedge clk);
        checks++;
        if (tig_signal !== 1'b0) begin
            failures++;
            $display("FAIL settle_hold: tig=%b, required 0", tig_signal);
        end
        @(negedge clk);
        checks++;
        if (tig_signal !== 1'b1) begin
            failures++;
            $display("FAIL fire_time: tig=%b, required 1", tig_signal);
        end
        wait_idle(3000, cyc, ok);
        checks++;
        if (!ok || resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL seed1_done: finished=%0d valid_at_busy_drop=%b, required 1 1", ok, resp_valid);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (trig_q.size() < 3 || trig_q[0] !== 16'h0001 || trig_q[1] !== 16'hB400 || trig_q[2] !== 16'h5A00) begin
            failures++;
            $display("FAIL seed1_first_chals: got %0d entries, required 0001 B400 5A00", trig_q.size());
        end
        errs = seq_errors(16'h0001);
        checks++;
        if (errs != 0) begin
            failures++;
            $display("FAIL seed1_chal_seq: %0d mismatches, required 0", errs);
        end
        checks++;
        if (resp_word !== exp_w) begin
            failures++;
            $display("FAIL seed1_word: got %h required %h", resp_word, exp_w);
        end
        checks++;
        if (valid_cnt - v0 != 1 || chal_glitch != 0) begin
            failures++;
            $display("FAIL seed1_pulses: valid=%0d glitches=%0d, required 1 0", valid_cnt - v0, chal_glitch);
        end
        last_word = exp_w;
    endtask

    task automatic test_seed0();
        int cyc; bit ok; logic [M-1:0] exp_w;
        trig_q.delete();
        exp_w = expected_word(16'h0001, bit_key);
        do_start(16'h0000);
        checks++;
        if (challenge !== 16'h0001) begin
            failures++;
            $display("FAIL seed0_first_chal: got %h required 0001", challenge);
        end
        wait_idle(3000, cyc, ok);
        checks++;
        if (!ok || resp_word !== exp_w) begin
            failures++;
            $display("FAIL seed0_word: finished=%0d got %h required %h", ok, resp_word, exp_w);
        end
        last_word = exp_w;
    endtask

    task automatic test_random();
        int cyc; bit ok; int errs; logic [N-1:0] s; logic [M-1:0] exp_w;
        for (int it = 0; it < 3; it++) begin
            s = 16'($urandom);
            bit_key = 16'($urandom) | 16'h0001;
            rise_dly = $urandom_range(1, 8);
            fall_dly = $urandom_range(1, 4);
            exp_w = expected_word(s, bit_key);
            trig_q.delete();
            repeat (10) @(negedge clk);
            do_start(s);
            wait_idle(4000, cyc, ok);
            repeat (2) @(negedge clk);
            errs = seq_errors(s);
            checks++;
            if (!ok || errs != 0 || resp_word !== exp_w) begin
                failures++;
                $display("FAIL random_batch seed=%h: finished=%0d seq_errs=%0d got %h required %h",
                         s, ok, errs, resp_word, exp_w);
            end
            last_word = exp_w;
        end
        rise_dly = 5; fall_dly = 2; bit_key = 16'h0001;
    endtask

    task automatic test_timeout_hi();
        int cyc; bit ok; int v0; logic [M-1:0] exp_w;
        repeat (10) @(negedge clk);
        puf_mode = MODE_LOW; v0 = valid_cnt;
        do_start(16'h1234);
        wait_idle(1000, cyc, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || timeout_err !== 1'b1 || tig_signal !== 1'b0 || valid_cnt != v0) begin
            failures++;
            $display("FAIL timeout_hi: finished=%0d terr=%b tig=%b valids=%0d, required 1 1 0 0",
                     ok, timeout_err, tig_signal, valid_cnt - v0);
        end
        checks++;
        if (cyc < TIMEOUT || cyc > TIMEOUT + SETTLE + 10) begin
            failures++;
            $display("FAIL timeout_hi_len: busy cycles=%0d, required %0d..%0d", cyc, TIMEOUT, TIMEOUT + SETTLE + 10);
        end
        checks++;
        if (resp_word !== last_word) begin
            failures++;
            $display("FAIL timeout_keeps_word: got %h required %h", resp_word, last_word);
        end
        puf_mode = MODE_NORMAL;
        exp_w = expected_word(16'h00A5, bit_key);
        do_start(16'h00A5);
        checks++;
        if (timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL timeout_clear: terr=%b required 0", timeout_err);
        end
        wait_idle(3000, cyc, ok);
        checks++;
        if (!ok || resp_word !== exp_w) begin
            failures++;
            $display("FAIL after_timeout_word: finished=%0d got %h required %h", ok, resp_word, exp_w);
        end
        last_word = exp_w;
    endtask

    task automatic test_timeout_lo();
        int cyc; bit ok; int v0;
        repeat (10) @(negedge clk);
        puf_mode = MODE_STUCK_HI; v0 = valid_cnt;
        do_start(16'h4321);
        wait_idle(2000, cyc, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || timeout_err !== 1'b1 || valid_cnt != v0 || tig_signal !== 1'b0) begin
            failures++;
            $display("FAIL timeout_lo: finished=%0d terr=%b valids=%0d tig=%b, required 1 1 0 0",
                     ok, timeout_err, valid_cnt - v0, tig_signal);
        end
        puf_mode = MODE_NORMAL;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_start_busy();
        int cyc; bit ok; int v0; logic [M-1:0] exp_w;
        trig_q.delete(); v0 = valid_cnt;
        exp_w = expected_word(16'hBEEF, bit_key);
        do_start(16'hBEEF);
        repeat (60) @(negedge clk);
        do_start(16'h0F0F);
        repeat (200) @(negedge clk);
        do_start(16'h7777);
        wait_idle(3000, cyc, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || resp_word !== exp_w || valid_cnt - v0 != 1 || seq_errors(16'hBEEF) != 0) begin
            failures++;
            $display("FAIL start_while_busy: finished=%0d got %h required %h valids=%0d",
                     ok, resp_word, exp_w, valid_cnt - v0);
        end
        last_word = exp_w;
    endtask

    task automatic test_reset_mid();
        int n; int v0;
        trig_q.delete(); v0 = valid_cnt;
        do_start(16'h2468);
        n = 0;
        while (trig_q.size() < 10 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (trig_q.size() < 10) begin
            failures++;
            $display("FAIL reach_bit10: triggers=%0d required 10", trig_q.size());
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (challenge !== 16'h0 || tig_signal !== 1'b0 || busy !== 1'b0 || resp_valid !== 1'b0 ||
            resp_word !== 32'h0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: chal=%h tig=%b busy=%b valid=%b word=%h terr=%b, required all 0",
                     challenge, tig_signal, busy, resp_valid, resp_word, timeout_err);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (valid_cnt != v0 || busy !== 1'b0 || tig_signal !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_quiet: valids=%0d busy=%b tig=%b, required 0 0 0",
                     valid_cnt - v0, busy, tig_signal);
        end
    endtask

    initial begin
        test_reset();
        test_seed1();
        test_seed0();
        test_random();
        test_timeout_hi();
        test_timeout_lo();
        test_start_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
